// File: rtl/fifo_rd.sv
// rtl/fifo_rd.sv - async FIFO read-side pointer, empty flag and occupancy (optional almost-empty via FIFO_RD_ALMOST_EMPTY_EN)
module fifo_rd #(
  parameter int PTR_WIDTH = 4,
  parameter int AE_THRESH = 2
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  input  logic                 r_inc,
  input  logic [PTR_WIDTH-1:0] rq2_wptr,
  output logic [PTR_WIDTH-2:0] r_addr,
  output logic                 r_empty,
  output logic [PTR_WIDTH-1:0] r_ptr,
  output logic [PTR_WIDTH-1:0] r_count
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  ,
  output logic                 r_almost_empty
`endif
);

  logic [PTR_WIDTH-1:0] rbin;
  logic [PTR_WIDTH-1:0] rbin_next;
  logic [PTR_WIDTH-1:0] rgray_next;
  logic [PTR_WIDTH-1:0] wbin;
  logic [PTR_WIDTH-1:0] r_count_next;
  logic                 r_empty_next;
  logic                 rd_en;

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  localparam logic [PTR_WIDTH-1:0] AE_LIMIT = AE_THRESH[PTR_WIDTH-1:0];
  logic r_almost_empty_next;
`endif

  // Pop only when something is present; a request while empty leaves the pointer alone
  always_comb begin
    rd_en        = r_inc & ~r_empty;
    rbin_next    = rbin + {{(PTR_WIDTH-1){1'b0}}, rd_en};
    rgray_next   = (rbin_next >> 1) ^ rbin_next;
    // full-width compare: same position with different wrap bit means full, not empty
    r_empty_next = (rgray_next == rq2_wptr);
  end

  // Gray-to-binary of the synchronized write pointer, XOR prefix from the MSB down
  always_comb begin
    wbin = '0;
    wbin[PTR_WIDTH-1] = rq2_wptr[PTR_WIDTH-1];
    for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
      wbin[i] = wbin[i+1] ^ rq2_wptr[i];
    end
    r_count_next = wbin - rbin_next;
  end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  // Almost-empty follows the post-pop occupancy, same edge as r_count
  always_comb begin
    r_almost_empty_next = (r_count_next <= AE_LIMIT);
  end

  // Registered almost-empty, asserted out of reset
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      r_almost_empty <= 1'b1;
    end else begin
      r_almost_empty <= r_almost_empty_next;
    end
  end
`endif

  // Pointer, empty and count all advance together so flags never lag the pointer
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      rbin    <= '0;
      r_ptr   <= '0;
      r_empty <= 1'b1;
      r_count <= '0;
    end else begin
      rbin    <= rbin_next;
      r_ptr   <= rgray_next;
      r_empty <= r_empty_next;
      r_count <= r_count_next;
    end
  end

  assign r_addr = rbin[PTR_WIDTH-2:0];

endmodule

// File: tb/tb_fifo_rd.sv
// tb/tb_fifo_rd.sv - self-checking bench for fifo_rd: directed vector table plus randomized model comparison
module tb_fifo_rd;

  logic       clk;
  logic       r_rst;
  logic       r_inc;
  logic [3:0] rq2_wptr;
  logic [2:0] r_addr;
  logic       r_empty;
  logic [3:0] r_ptr;
  logic [3:0] r_count;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic       r_almost_empty;
`endif

  int n_cmp;
  int n_bad;

  fifo_rd #(.PTR_WIDTH(4), .AE_THRESH(2)) dut (
    .r_clk    (clk),
    .r_rst    (r_rst),
    .r_inc    (r_inc),
    .rq2_wptr (rq2_wptr),
    .r_addr   (r_addr),
    .r_empty  (r_empty),
    .r_ptr    (r_ptr),
    .r_count  (r_count)
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    ,
    .r_almost_empty (r_almost_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       inc;
    logic [3:0] wptr;
    logic [2:0] e_addr;
    logic [3:0] e_ptr;
    logic       e_empty;
    logic [3:0] e_count;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v;
    v = b[3:0];
    return v ^ (v >> 1);
  endfunction

  function automatic void add(input logic rst, input logic inc, input logic [3:0] wptr,
                              input int e_bin, input logic e_empty, input int e_count);
    vec_t v;
    v.rst = rst; v.inc = inc; v.wptr = wptr;
    v.e_addr = 3'(e_bin % 8);
    v.e_ptr = to_gray(e_bin);
    v.e_empty = e_empty;
    v.e_count = e_count[3:0];
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e_addr, input int e_ptr,
                         input int e_empty, input int e_count);
    chk({tag, ".r_addr"}, int'(r_addr), e_addr);
    chk({tag, ".r_ptr"}, int'(r_ptr), e_ptr);
    chk({tag, ".r_empty"}, int'(r_empty), e_empty);
    chk({tag, ".r_count"}, int'(r_count), e_count);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    chk({tag, ".r_almost_empty"}, int'(r_almost_empty), (e_count <= 2) ? 1 : 0);
`endif
  endtask

  task automatic step(input logic rst, input logic inc, input logic [3:0] wptr);
    r_rst = rst; r_inc = inc; rq2_wptr = wptr;
    @(posedge clk);
    #1;
  endtask

  int m_rd, m_w, m_cnt, occ;
  logic m_empty, rr, ri;

  initial begin
    n_cmp = 0; n_bad = 0;
    r_rst = 1'b1; r_inc = 1'b0; rq2_wptr = '0;

    // reset with inc asserted and a nonzero write pointer
    add(1, 1, 4'b0111, 0, 1, 0);
    add(1, 1, 4'b0111, 0, 1, 0);
    // underflow: reads while empty are ignored
    for (int i = 0; i < 10; i++) add(0, 1, 4'b0000, 0, 1, 0);
    // drain 5
    add(0, 0, 4'b0111, 0, 0, 5);
    for (int i = 1; i <= 5; i++) add(0, 1, 4'b0111, i, (i == 5), 5 - i);
    add(0, 1, 4'b0111, 5, 1, 0);
    // three more written, then reset at count 3, no pop on release
    add(0, 0, to_gray(8), 5, 0, 3);
    add(1, 1, to_gray(8), 0, 1, 0);
    add(0, 1, 4'b0000, 0, 1, 0);
    add(0, 1, 4'b0000, 0, 1, 0);
    // wrap: 8 in, 8 out so rbin reaches 8
    add(0, 0, to_gray(8), 0, 0, 8);
    for (int i = 1; i <= 8; i++) add(0, 1, to_gray(8), i, (i == 8), 8 - i);
    // write pointer binary 15 -> seven entries across the wrap
    add(0, 0, 4'b1000, 8, 0, 7);
    for (int i = 1; i <= 7; i++) add(0, 1, 4'b1000, 8 + i, (i == 7), 7 - i);
    // simultaneous pop and write at count 1, also wraps rbin to 0
    add(0, 0, to_gray(16), 15, 0, 1);
    add(0, 1, to_gray(17), 16, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].inc, vecs[i].wptr);
      chk_all($sformatf("vec%0d", i), int'(vecs[i].e_addr), int'(vecs[i].e_ptr),
              int'(vecs[i].e_empty), int'(vecs[i].e_count));
    end

    // randomized traffic against an occupancy model
    step(1, 0, 4'b0000);
    m_rd = 0; m_w = 0; m_empty = 1'b1;
    for (int c = 0; c < 600; c++) begin
      rr = ($urandom_range(0, 63) == 0);
      ri = ($urandom_range(0, 2) != 0);
      if (rr) begin
        m_w = 0;
      end else begin
        occ = (m_w - m_rd) & 15;
        if (occ < 8 && $urandom_range(0, 1) == 1) m_w = (m_w + 1) % 16;
      end
      step(rr, ri, to_gray(m_w));
      if (rr) begin
        m_rd = 0; m_cnt = 0; m_empty = 1'b1;
      end else begin
        if (ri && !m_empty) m_rd = (m_rd + 1) % 16;
        m_cnt = (m_w - m_rd) & 15;
        m_empty = (m_cnt == 0);
      end
      chk_all($sformatf("rnd%0d", c), m_rd % 8, int'(to_gray(m_rd)), int'(m_empty), m_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
